turfio_cout_mc: RTL and testbench
=================================

Name: turfio_cout_mc

Overview:
- Multi-channel, parametrised command-output framer for the TURF→TURFIO command path.
- Takes 32-bit commands through a small valid/ready FIFO and slices them into fixed-length frames. Each frame is CMD_WIDTH/SER_WIDTH beats of SER_WIDTH-bit parallel words, one beat per clock, for downstream serialisers.
- Each of NCH channels independently sends a training pattern or live traffic (command or idle word), switching only at frame boundaries.
- Frame alignment can be forced by an external sync strobe.

Parameters:
- CMD_WIDTH, 32, command word width in bits.
- SER_WIDTH, 8, parallel output word per channel per beat; CMD_WIDTH must be a multiple of it (elaboration error otherwise).
- NCH, 4, number of output channels.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, ≥2.
- TRAIN_PATTERN, 32'hA55A6996, word sent by training channels.
- IDLE_WORD, 32'h00000000, word sent by live channels when the FIFO is empty.

Ports:
- if_clk_i  in  1  interface clock; all logic on its rising edge.
- if_rstn_i  in  1  reset, asynchronous assert, active-low.
- cmd_tdata_i  in  CMD_WIDTH  command word.
- cmd_tvalid_i  in  1  command valid.
- cmd_tready_o  out  1  FIFO not full.
- train_i  in  NCH  per-channel training request.
- sync_i  in  1  frame realign strobe.
- cout_data_o  out  NCH*SER_WIDTH  channel c occupies bits [c*SER_WIDTH +: SER_WIDTH].
- frame_start_o  out  1  high with beat 0 of every frame on cout_data_o.
- cmd_sent_o  out  1  one-cycle pulse when a command is popped for transmission.
- frame_count_o  out  16  frames started since reset.

Behaviour:
- BEATS = CMD_WIDTH/SER_WIDTH. Beat counter runs 0..BEATS-1 and wraps to 0.
- Reset (if_rstn_i low): all outputs 0, cmd_tready_o 0, FIFO empty, beat counter 0, train latch all ones.
- Reset release: cmd_tready_o goes 1 on the first edge. A frame load occurs on that same first edge.
- Handshake: a push occurs on an edge with cmd_tvalid_i & cmd_tready_o. cmd_tready_o = !full, registered. There is no push when full.
- Load edge: any edge where beat counter == 0 (or forced by sync_i). On a load edge:
  - Latch train_i into the per-channel train latch. train_i is ignored at all other edges.
  - Channel c loads TRAIN_PATTERN if latch[c]=1.
  - Otherwise channel c loads the FIFO head if the FIFO is non-empty, else IDLE_WORD.
  - Live channels all carry the same command; commands are broadcast.
  - Pop occurs iff the FIFO is non-empty and at least one latch bit is 0. With every channel training, no pop occurs and commands wait.
  - cmd_sent_o pulses on the cycle the popped word's beat 0 appears.
- Push/pop timing: a command pushed at edge N is eligible only for loads at edge N+1 or later. A push on a load edge with an empty FIFO is not popped on that edge. Push and pop on the same edge are both honoured and occupancy is unchanged.
- Output ordering: MSB first. Beat k presents word[CMD_WIDTH-1-k*SER_WIDTH -: SER_WIDTH].
- Output timing: cout_data_o is registered. Beat 0 appears the cycle after the load edge and is held for one cycle per beat.
- frame_start_o is high with beat 0. frame_count_o increments at the same edge and wraps 0xFFFF→0.
- sync_i high at an edge forces that edge to be a load edge and resets the beat counter.
  - Mid-frame, the in-flight word is abandoned.
  - If the abandoned word was a popped command, the command is restarted from beat 0 with no new pop and no second cmd_sent_o. Training/idle words are simply reloaded.
  - sync_i at beat 0 has no extra effect.
- Reset mid-frame: output returns to 0 immediately. All FIFO contents are discarded.

Test Plan:
- Reset held, then released with train_i=4'hF, sync_i=0 → after release, each channel repeats A5,5A,69,96 with frame_start_o on A5; cmd_tready_o=1; frame_count_o increments by 1 per 4 cycles.
- train_i=0, push 32'h00010000 once → next frame all channels 00,01,00,00; cmd_sent_o one pulse with the 00 beat; following frames 00,00,00,00.
- train_i=4'b0101, push 32'h12345678 → channels 0,2 send A5,5A,69,96; channels 1,3 send 12,34,56,78 in the same frame; one cmd_sent_o pulse.
- train_i=4'hF, push 5 commands back-to-back → cmd_tready_o drops after the 4th; 5th is held on tvalid. Drop train_i to 0 → commands appear in push order, one per frame; tready reasserts after the first pop.
- Command 32'hDEADBEEF in flight, assert sync_i on beat 2 → output DE,AD then restarts at DE,AD,BE,EF with frame_start_o; only one cmd_sent_o; next frame is idle.
- Pull if_rstn_i low at beat 1 with 2 commands queued → cout_data_o=0 asynchronously; after release the FIFO is empty and the first frame is training (latch reset to ones).

Source files
------------

// File: rtl/turfio_cout_mc.sv
// turfio_cout_mc: multi-channel command-output framer.
// Queues 32-bit commands in a small FIFO and slices them, MSB first, into
// fixed-length frames of SER_WIDTH-bit beats on every channel. Channels that
// request training send TRAIN_PATTERN. The other channels share the queued
// command, or send IDLE_WORD when the queue is empty.
module turfio_cout_mc #(
   parameter int unsigned          CMD_WIDTH     = 32,
   parameter int unsigned          SER_WIDTH     = 8,
   parameter int unsigned          NCH           = 4,
   parameter int unsigned          FIFO_DEPTH    = 4,
   parameter logic [CMD_WIDTH-1:0] TRAIN_PATTERN = 32'hA55A6996,
   parameter logic [CMD_WIDTH-1:0] IDLE_WORD     = 32'h00000000
) (
   input  logic                     if_clk_i,
   input  logic                     if_rstn_i,
   input  logic [CMD_WIDTH-1:0]     cmd_tdata_i,
   input  logic                     cmd_tvalid_i,
   output logic                     cmd_tready_o,
   input  logic [NCH-1:0]           train_i,
   input  logic                     sync_i,
   output logic [NCH*SER_WIDTH-1:0] cout_data_o,
   output logic                     frame_start_o,
   output logic                     cmd_sent_o,
   output logic [15:0]              frame_count_o
);

   localparam int unsigned BEATS = CMD_WIDTH / SER_WIDTH;
   localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CW    = AW + 1;

   // Reject parameter sets that cannot form whole frames or a ring-pointer FIFO
   if ((CMD_WIDTH % SER_WIDTH) != 0 || BEATS == 0) begin : g_bad_width
      $error("turfio_cout_mc: CMD_WIDTH must be a non-zero multiple of SER_WIDTH");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("turfio_cout_mc: FIFO_DEPTH must be a power of 2 and at least 2");
   end

   // FIFO storage and bookkeeping
   logic [CMD_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wptr;
   logic [AW-1:0]        r_rptr;
   logic [CW-1:0]        r_count;
   logic                 r_tready;

   // Framing state
   logic [NCH-1:0]                     r_latch;
   logic [BW-1:0]                      r_beat;
   logic [NCH-1:0][CMD_WIDTH-1:0]      r_shift;
   logic [CMD_WIDTH-1:0]               r_cmd;
   logic                               r_cur_cmd;
   logic [NCH-1:0][SER_WIDTH-1:0]      r_cout;
   logic                               r_frame_start;
   logic                               r_cmd_sent;
   logic [15:0]                        r_frame_count;

   logic                               w_push;
   logic                               w_empty;
   logic                               w_load;
   logic [NCH-1:0]                     w_train;
   logic                               w_any_live;
   logic                               w_restart;
   logic                               w_pop;
   logic [CW-1:0]                      w_count_nxt;
   logic [CMD_WIDTH-1:0]               w_live_word;
   logic [NCH-1:0][CMD_WIDTH-1:0]      w_frame;
   logic [BW-1:0]                      w_beat_base;
   logic [BW-1:0]                      w_beat_nxt;

   // Handshake, load decision and pop qualification
   assign w_push      = cmd_tvalid_i & r_tready;
   assign w_empty     = (r_count == '0);
   assign w_load      = (r_beat == '0) | sync_i;
   assign w_train     = w_load ? train_i : r_latch;
   assign w_any_live  = ~(&w_train);
   assign w_restart   = sync_i & (r_beat != '0) & r_cur_cmd;
   assign w_pop       = w_load & ~w_restart & ~w_empty & w_any_live;
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

   // Beat counter: a load edge restarts the frame at beat 0
   assign w_beat_base = w_load ? '0 : r_beat;
   assign w_beat_nxt  = (w_beat_base == BW'(BEATS - 1)) ? '0 : w_beat_base + BW'(1);

   // Word for live channels: restarted command, FIFO head, or idle
   always_comb begin
      w_live_word = IDLE_WORD;
      if (w_restart) begin
         w_live_word = r_cmd;
      end else if (!w_empty) begin
         w_live_word = r_mem[r_rptr];
      end
   end

   // Per-channel frame word selection
   for (genvar c = 0; c < NCH; c++) begin : g_frame
      assign w_frame[c] = w_train[c] ? TRAIN_PATTERN : w_live_word;
   end

   // FIFO storage write (contents need no reset; pointers define validity)
   always_ff @(posedge if_clk_i) begin
      if (w_push) begin
         r_mem[r_wptr] <= cmd_tdata_i;
      end
   end

   // FIFO pointers, occupancy and registered ready
   always_ff @(posedge if_clk_i or negedge if_rstn_i) begin
      if (!if_rstn_i) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_tready <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         r_count  <= w_count_nxt;
         r_tready <= (w_count_nxt != CW'(FIFO_DEPTH));
      end
   end

   // Frame control: beat counter, train latch, in-flight command tracking
   always_ff @(posedge if_clk_i or negedge if_rstn_i) begin
      if (!if_rstn_i) begin
         r_beat        <= '0;
         r_latch       <= '1;
         r_cmd         <= '0;
         r_cur_cmd     <= 1'b0;
         r_frame_start <= 1'b0;
         r_cmd_sent    <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_beat        <= w_beat_nxt;
         r_frame_start <= w_load;
         r_cmd_sent    <= w_pop;
         if (w_pop) begin
            r_cmd <= r_mem[r_rptr];
         end
         if (w_load) begin
            r_latch       <= train_i;
            r_cur_cmd     <= w_pop | (w_restart & w_any_live);
            r_frame_count <= r_frame_count + 16'd1;
         end
      end
   end

   // Output shifters: present the top SER_WIDTH bits, shift left each beat
   always_ff @(posedge if_clk_i or negedge if_rstn_i) begin
      if (!if_rstn_i) begin
         r_shift <= '0;
         r_cout  <= '0;
      end else begin
         for (int unsigned c = 0; c < NCH; c++) begin
            if (w_load) begin
               r_cout[c]  <= w_frame[c][CMD_WIDTH-1 -: SER_WIDTH];
               r_shift[c] <= w_frame[c] << SER_WIDTH;
            end else begin
               r_cout[c]  <= r_shift[c][CMD_WIDTH-1 -: SER_WIDTH];
               r_shift[c] <= r_shift[c] << SER_WIDTH;
            end
         end
      end
   end

   assign cmd_tready_o  = r_tready;
   assign cout_data_o   = r_cout;
   assign frame_start_o = r_frame_start;
   assign cmd_sent_o    = r_cmd_sent;
   assign frame_count_o = r_frame_count;

endmodule

// File: tb/tb_turfio_cout_mc.sv
// Testbench for turfio_cout_mc: directed scenarios plus randomized traffic,
// checked cycle by cycle against a queue-based reference model.
module tb_turfio_cout_mc;

   localparam int unsigned CW    = 32;
   localparam int unsigned SW    = 8;
   localparam int unsigned NCH   = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned BEATS = CW / SW;
   localparam logic [31:0] TRAIN = 32'hA55A6996;
   localparam logic [31:0] IDLE  = 32'h00000000;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [CW-1:0]     cmd_tdata = '0;
   logic              cmd_tvalid = 1'b0;
   logic              cmd_tready;
   logic [NCH-1:0]    train = '1;
   logic              sync = 1'b0;
   logic [NCH*SW-1:0] cout_data;
   logic              frame_start;
   logic              cmd_sent;
   logic [15:0]       frame_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   turfio_cout_mc #(
      .CMD_WIDTH(CW), .SER_WIDTH(SW), .NCH(NCH), .FIFO_DEPTH(DEPTH),
      .TRAIN_PATTERN(TRAIN), .IDLE_WORD(IDLE)
   ) dut (
      .if_clk_i(clk), .if_rstn_i(rstn),
      .cmd_tdata_i(cmd_tdata), .cmd_tvalid_i(cmd_tvalid), .cmd_tready_o(cmd_tready),
      .train_i(train), .sync_i(sync),
      .cout_data_o(cout_data), .frame_start_o(frame_start),
      .cmd_sent_o(cmd_sent), .frame_count_o(frame_count)
   );

   typedef struct {
      logic [NCH*SW-1:0] data;
      logic              fs;
      logic              sent;
      logic [15:0]       cnt;
      logic              rdy;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state: command queue, frame position, frame words
   logic [31:0]    mq[$];
   int             pos;
   logic [NCH-1:0] mlatch;
   logic [31:0]    mwords[NCH];
   logic [31:0]    mcmd;
   logic [31:0]    lw;
   bit             mcur;
   bit             mready;
   bit             mload;
   bit             mrestart;
   bit             mpop;
   bit             mlive;
   int             nb;
   logic [15:0]    mcnt;
   exp_t           me;

   // Model: at each edge predict what the DUT will present for the next cycle
   initial forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
         mq.delete();
         sb.delete();
         pos = 0; mlatch = '1; mcur = 0; mready = 0; mcnt = '0; mcmd = '0;
         for (int c = 0; c < NCH; c++) mwords[c] = '0;
      end else begin
         mload = (pos == 0) || sync;
         mpop = 0;
         if (mload) begin
            mrestart = sync && (pos != 0) && mcur;
            mlatch = train;
            mlive = (mlatch != '1);
            if (mrestart) begin
               lw = mcmd;
               mcur = mlive;
            end else if (mlive && mq.size() > 0) begin
               mcmd = mq.pop_front();
               lw = mcmd;
               mpop = 1;
               mcur = 1;
            end else begin
               lw = IDLE;
               mcur = 0;
            end
            for (int c = 0; c < NCH; c++) mwords[c] = mlatch[c] ? TRAIN : lw;
            mcnt = mcnt + 16'd1;
            nb = 0;
         end else begin
            nb = pos;
         end
         me.data = '0;
         for (int c = 0; c < NCH; c++)
            me.data[c*SW +: SW] = 8'(mwords[c] >> (CW - SW * (nb + 1)));
         me.fs = mload;
         me.sent = mpop;
         me.cnt = mcnt;
         if (cmd_tvalid && mready) mq.push_back(cmd_tdata);
         mready = (mq.size() < DEPTH);
         me.rdy = mready;
         pos = (nb + 1) % BEATS;
         sb.push_back(me);
      end
   end

   // Monitor: compare DUT outputs mid-cycle against the scoreboard
   exp_t ge;
   initial forever begin
      @(negedge clk);
      if (!rstn || sb.size() == 0) begin
         chk("reset_cout", 64'(cout_data), 64'(0));
         chk("reset_ctrl", 64'({frame_start, cmd_sent, cmd_tready, frame_count}), 64'(0));
      end else begin
         ge = sb.pop_front();
         chk("cout_data",   64'(cout_data),   64'(ge.data));
         chk("frame_start", 64'(frame_start), 64'(ge.fs));
         chk("cmd_sent",    64'(cmd_sent),    64'(ge.sent));
         chk("frame_count", 64'(frame_count), 64'(ge.cnt));
         chk("cmd_tready",  64'(cmd_tready),  64'(ge.rdy));
      end
   end

   // Push one command, holding valid until accepted (called at a negedge)
   task automatic push(input logic [31:0] d);
      bit acc;
      int n;
      acc = 0; n = 0;
      cmd_tdata = d;
      cmd_tvalid = 1'b1;
      while (!acc && n < 200) begin
         acc = cmd_tready;
         @(negedge clk);
         n++;
      end
      cmd_tvalid = 1'b0;
      if (!acc) chk("push_timeout", 64'(0), 64'(1));
   endtask

   // Wait until the DUT shows a given event; a timeout counts as a failure
   task automatic wait_sent();
      int n;
      n = 0;
      while (!cmd_sent && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_sent) chk("wait_sent_timeout", 64'(0), 64'(1));
   endtask

   task automatic wait_fs();
      int n;
      n = 0;
      while (!frame_start && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!frame_start) chk("wait_fs_timeout", 64'(0), 64'(1));
   endtask

   // Overall time limit
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (20) @(negedge clk);

      // Single broadcast command
      train = '0;
      repeat (8) @(negedge clk);
      push(32'h00010000);
      repeat (16) @(negedge clk);

      // Mixed training and live channels
      train = 4'b0101;
      repeat (8) @(negedge clk);
      push(32'h12345678);
      repeat (16) @(negedge clk);

      // Fill FIFO while all channels train, then release
      train = '1;
      repeat (8) @(negedge clk);
      fork
         begin
            for (int i = 0; i < 5; i++) push(32'hC0DE0000 + 32'(i));
         end
         begin
            repeat (24) @(negedge clk);
            train = '0;
         end
      join
      repeat (40) @(negedge clk);

      // Sync mid-frame restarts the in-flight command
      push(32'hDEADBEEF);
      wait_sent();
      @(negedge clk);
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      repeat (16) @(negedge clk);

      // Reset mid-frame with commands queued
      train = '1;
      repeat (8) @(negedge clk);
      push(32'h11111111);
      push(32'h22222222);
      wait_fs();
      @(posedge clk);
      #2 rstn = 1'b0;
      #1 chk("async_reset_cout", 64'(cout_data), 64'(0));
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (12) @(negedge clk);
      train = '0;
      repeat (16) @(negedge clk);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         cmd_tvalid = 1'($urandom_range(0, 1));
         cmd_tdata  = $urandom;
         sync       = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 7) == 0) train = NCH'($urandom);
         if ($urandom_range(0, 399) == 0) begin
            #2 rstn = 1'b0;
            @(negedge clk);
            #2 rstn = 1'b1;
         end
      end
      @(negedge clk);
      cmd_tvalid = 1'b0;
      sync = 1'b0;
      repeat (8) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
